// File: rtl/slurm32_fetch_pkg.sv
// rtl/slurm32_fetch_pkg.sv - shared widths and types for the SLURM32 fetch queue
package slurm32_fetch_pkg;

   localparam int SLURM32_ADDR_W = 30;
   localparam int SLURM32_INSN_W = 32;

   // Only the instruction is stored; the head address is tracked separately.
   typedef struct packed {
      logic [SLURM32_INSN_W-1:0] instruction;
   } fetch_entry_t;

endpackage

// File: rtl/slurm32_sync_fifo.sv
// rtl/slurm32_sync_fifo.sv - pointer-based synchronous FIFO with flush
module slurm32_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RSTb,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop & ~empty;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push   = push & (~full | do_pop);
   assign head_data = storage[rd_ptr];

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            storage[wr_ptr] <= push_data;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/slurm32_fetch_queue.sv
// rtl/slurm32_fetch_queue.sv - pipelined SLURM32 instruction fetcher with flushable return FIFO
module slurm32_fetch_queue
   import slurm32_fetch_pkg::*;
#(
   parameter int                DEPTH           = 4,
   parameter int                MAX_OUTSTANDING = 4,
   parameter int                ADDR_W          = SLURM32_ADDR_W,
   parameter int                DATA_W          = SLURM32_INSN_W,
   parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
   input  logic              CLK,
   input  logic              RSTb,
   output logic              mem_request,
   output logic [ADDR_W-1:0] mem_address,
   input  logic              mem_ready,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_data,
   output logic              instruction_valid,
   output logic [DATA_W-1:0] instruction_out,
   output logic [ADDR_W-1:0] instruction_address_out,
   input  logic              instruction_ready,
   input  logic              halt_request,
   input  logic              load_pc_request,
   input  logic [ADDR_W-1:0] load_pc_address
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int OUT_W = 4;
   localparam int SUM_W = 6;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] head_pc;
   logic [OUT_W-1:0]  outstanding;
   logic [OUT_W-1:0]  outstanding_next;
   logic [OUT_W-1:0]  drop;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic [SUM_W-1:0]  reserved;
   logic              accept;
   logic              pop;
   logic              push;
   logic              discard;

   // Every live in-flight read owns a FIFO slot, so a return can never overflow.
   assign reserved    = SUM_W'(fifo_count) + SUM_W'(outstanding) - SUM_W'(drop);
   assign mem_request = RSTb & ~halt_request & ~load_pc_request
                      & (int'(outstanding) < MAX_OUTSTANDING)
                      & (int'(reserved) < DEPTH);
   assign mem_address = fetch_pc;

   assign accept  = mem_request & mem_ready;
   assign pop     = instruction_valid & instruction_ready & ~load_pc_request;
   assign discard = (drop != '0);
   assign push    = mem_valid & ~discard & ~load_pc_request & (~fifo_full | pop);

   assign instruction_valid       = ~fifo_empty;
   assign instruction_address_out = head_pc;

   always_comb begin
      outstanding_next = outstanding;
      if (accept && !mem_valid) begin
         outstanding_next = outstanding + OUT_W'(1);
      end else if (!accept && mem_valid && outstanding != '0) begin
         outstanding_next = outstanding - OUT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         fetch_pc    <= RESET_PC;
         head_pc     <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (load_pc_request) begin
            // Everything still in flight after this edge is stale, including a word returning now.
            fetch_pc <= load_pc_address;
            head_pc  <= load_pc_address;
            drop     <= outstanding_next;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            if (pop) begin
               head_pc <= head_pc + ADDR_W'(1);
            end
            if (mem_valid && discard) begin
               drop <= drop - OUT_W'(1);
            end
         end
      end
   end

   slurm32_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RSTb      (RSTb),
      .push      (push),
      .push_data (mem_data),
      .pop       (pop),
      .head_data (instruction_out),
      .flush     (load_pc_request),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule
